// File: rtl/ipu_frame_sequencer.sv
// Frame-level controller for the image processing unit: streams pixels into the
// IPU one at a time with a frame-constant B/opSel and streams results out.
module ipu_frame_sequencer #(
  parameter int unsigned FRAME_PIXELS = 196608,
  parameter int unsigned IPU_LAT      = 1,
  parameter int unsigned CNT_W        = 18
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_opSel,
  input  logic [7:0]       cfg_B,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       ipu_A,
  output logic [7:0]       ipu_B,
  output logic [1:0]       ipu_opSel,
  output logic             ipu_Load,
  input  logic [15:0]      ipu_C,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pix_count
);

  localparam int unsigned      LAT_W    = $clog2(IPU_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         ipu_a_q, ipu_a_d;
  logic [7:0]         ipu_b_q, ipu_b_d;
  logic [1:0]         ipu_op_q, ipu_op_d;
  logic               load_q, load_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [15:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   pix_q, pix_d;

  // Abort takes precedence, so a pixel is never accepted in the cycle it is raised.
  assign in_ready = (state_q == S_ISSUE) && !abort;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    ipu_a_d     = ipu_a_q;
    ipu_b_d     = ipu_b_q;
    ipu_op_d    = ipu_op_q;
    load_d      = 1'b0;
    lat_d       = lat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pix_d       = pix_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ipu_b_d  = cfg_B;
          ipu_op_d = cfg_opSel;
          pix_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (in_valid && in_ready) begin
          ipu_a_d = in_data;
          load_d  = 1'b1;
          lat_d   = LAT_W'(IPU_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The count reaches zero on the edge the IPU samples Load; C is captured one edge later.
        if (lat_q == '0) begin
          out_data_d  = ipu_C;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pix_d       = pix_q + CNT_W'(1);
          state_d     = (pix_q == LAST_PIX) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      ipu_a_d     = ipu_a_q;
      load_d      = 1'b0;
      lat_d       = lat_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      pix_d       = pix_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      ipu_a_q     <= '0;
      ipu_b_q     <= '0;
      ipu_op_q    <= '0;
      load_q      <= 1'b0;
      lat_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      ipu_a_q     <= ipu_a_d;
      ipu_b_q     <= ipu_b_d;
      ipu_op_q    <= ipu_op_d;
      load_q      <= load_d;
      lat_q       <= lat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
    end
  end

  assign ipu_A     = ipu_a_q;
  assign ipu_B     = ipu_b_q;
  assign ipu_opSel = ipu_op_q;
  assign ipu_Load  = load_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pix_count = pix_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Directed bench for ipu_frame_sequencer with a small registered IPU stand-in
// (op 0: A+B, 1: A*B, 2: A-B, 3: A^B; result valid one cycle after Load).
module tb_ipu_frame_sequencer;

  localparam int FP = 4;
  localparam int CW = 3;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [1:0]    cfg_opSel = '0;
  logic [7:0]    cfg_B = '0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    ipu_A, ipu_B;
  logic [1:0]    ipu_opSel;
  logic          ipu_Load;
  logic [15:0]   ipu_C = '0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy, done;
  logic [CW-1:0] pix_count;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_load = 0, n_done = 0, last_load = 0, load_gap = 0;

  always #5 Clk = ~Clk;

  ipu_frame_sequencer #(.FRAME_PIXELS(FP), .IPU_LAT(1), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
    .cfg_opSel(cfg_opSel), .cfg_B(cfg_B),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ipu_A(ipu_A), .ipu_B(ipu_B), .ipu_opSel(ipu_opSel), .ipu_Load(ipu_Load),
    .ipu_C(ipu_C), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .pix_count(pix_count)
  );

  function automatic logic [15:0] ipu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return {8'd0, a} + {8'd0, b};
      2'd1:    return 16'(a) * 16'(b);
      2'd2:    return {8'd0, a} - {8'd0, b};
      default: return {8'd0, a ^ b};
    endcase
  endfunction

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (ipu_Load) begin
      ipu_C     <= ipu_f(ipu_A, ipu_B, ipu_opSel);
      n_load    <= n_load + 1;
      load_gap  <= cyc - last_load;
      last_load <= cyc;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_frame(input string tag, input logic [7:0] b, input logic [1:0] op);
    cfg_B = b; cfg_opSel = op; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_pix0"}, 32'(pix_count), 0);
    check({tag, "_ipu_b"}, 32'(ipu_B), 32'(b));
    check({tag, "_ipu_op"}, 32'(ipu_opSel), 32'(op));
  endtask

  task automatic send(input string tag, input logic [7:0] d, input int gap);
    int t = 0;
    while (!in_ready && t < 40) begin @(negedge Clk); t++; end
    if (!in_ready) check({tag, "_in_ready_timeout"}, 0, 1);
    repeat (gap) @(negedge Clk);
    in_valid = 1'b1; in_data = d;
    @(negedge Clk);
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic wait_out(input string tag);
    int t = 0;
    while (!out_valid && t < 40) begin @(negedge Clk); t++; end
    if (!out_valid) check({tag, "_out_valid_timeout"}, 0, 1);
  endtask

  task automatic recv(input string tag, input logic [15:0] exp);
    wait_out(tag);
    check(tag, 32'(out_data), 32'(exp));
  endtask

  task automatic end_frame(input string tag, input int done_before);
    @(negedge Clk);
    check({tag, "_done_pulse"}, 32'(done), 1);
    check({tag, "_pix_final"}, 32'(pix_count), FP);
    @(negedge Clk);
    check({tag, "_done_low"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_done_once"}, 32'(n_done - done_before), 1);
  endtask

  initial begin
    int d0, l0;
    logic [7:0]  t2_px [4] = '{8'h01, 8'h10, 8'h7F, 8'hFF};
    logic [15:0] t2_ex [4] = '{16'h0002, 16'h0020, 16'h00FE, 16'h01FE};
    logic [7:0]  t4_px [4] = '{8'h00, 8'h0F, 8'hF0, 8'h55};
    logic [15:0] t4_ex [4] = '{16'h000F, 16'h0000, 16'h00FF, 16'h005A};

    // Reset values
    @(negedge Clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_outs", {ipu_A, ipu_B, ipu_opSel, ipu_Load, out_valid, done, pix_count}, 0);
    check("rst_out_data", 32'(out_data), 0);
    Rst = 1'b0;
    @(negedge Clk);

    // T2: multiply frame, back-to-back throughput
    d0 = n_done;
    start_frame("t2", 8'h02, 2'b01);
    for (int i = 0; i < FP; i++) begin
      send("t2", t2_px[i], 0);
      recv($sformatf("t2_px%0d", i), t2_ex[i]);
      if (i == 2) check("t2_load_period", 32'(load_gap), 4);
    end
    end_frame("t2", d0);

    // Start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge Clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_wins", 32'(busy), 0);

    // T3: output backpressure on pixel 1
    d0 = n_done;
    start_frame("t3", 8'h10, 2'b00);
    send("t3", 8'h20, 0);
    recv("t3_px0", 16'h0030);
    send("t3", 8'hF0, 0);
    out_ready = 1'b0;
    wait_out("t3_bp");
    l0 = n_load;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_bp_data%0d", i), 32'(out_data), 32'h0100);
      check($sformatf("t3_bp_hold%0d", i), {30'd0, out_valid, in_ready}, 32'b10);
      @(negedge Clk);
    end
    check("t3_bp_no_load", 32'(n_load - l0), 0);
    out_ready = 1'b1;
    @(negedge Clk);
    check("t3_bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    check("t3_bp_pix", 32'(pix_count), 2);
    send("t3", 8'h01, 0);
    recv("t3_px2", 16'h0011);
    send("t3", 8'h00, 0);
    recv("t3_px3", 16'h0010);
    end_frame("t3", d0);

    // T4: input starvation gaps 0..3
    d0 = n_done;
    l0 = n_load;
    start_frame("t4", 8'h0F, 2'b11);
    for (int i = 0; i < FP; i++) begin
      send("t4", t4_px[i], i);
      recv($sformatf("t4_px%0d", i), t4_ex[i]);
    end
    end_frame("t4", d0);
    check("t4_load_count", 32'(n_load - l0), FP);

    // T5: abort in WAIT of pixel 2, then a fresh frame with B=3
    d0 = n_done;
    start_frame("t5a", 8'h01, 2'b10);
    send("t5a", 8'h10, 0);
    recv("t5a_px0", 16'h000F);
    send("t5a", 8'h20, 0);
    recv("t5a_px1", 16'h001F);
    send("t5a", 8'h30, 0);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    check("t5_abort_idle", 32'(busy), 0);
    check("t5_abort_outs", {30'd0, out_valid, ipu_Load}, 0);
    check("t5_abort_pix", 32'(pix_count), 2);
    repeat (3) @(negedge Clk);
    check("t5_abort_no_done", 32'(n_done - d0), 0);
    check("t5_abort_stays_idle", {30'd0, busy, out_valid}, 0);
    start_frame("t5b", 8'h03, 2'b01);
    send("t5b", 8'h05, 0);
    recv("t5b_px0", 16'h000F);
    send("t5b", 8'h10, 0);
    recv("t5b_px1", 16'h0030);
    send("t5b", 8'h00, 0);
    recv("t5b_px2", 16'h0000);
    send("t5b", 8'h55, 0);
    recv("t5b_px3", 16'h00FF);
    end_frame("t5b", d0);

    // T6: cfg and start toggled mid-frame are ignored
    d0 = n_done;
    start_frame("t6", 8'h04, 2'b00);
    send("t6", 8'h01, 0);
    cfg_B = 8'hAA; cfg_opSel = 2'b11; start = 1'b1;
    recv("t6_px0", 16'h0005);
    @(negedge Clk);
    start = 1'b0;
    check("t6_cfg_hold", {22'd0, ipu_B, ipu_opSel}, {22'd0, 8'h04, 2'b00});
    send("t6", 8'h02, 0);
    recv("t6_px1", 16'h0006);
    send("t6", 8'hFC, 0);
    recv("t6_px2", 16'h0100);
    send("t6", 8'hFF, 0);
    recv("t6_px3", 16'h0103);
    end_frame("t6", d0);

    // T1: reset asserted mid-WAIT
    start_frame("t1", 8'h07, 2'b00);
    send("t1", 8'h11, 0);
    check("t1_in_wait", {30'd0, busy, in_ready}, 32'b10);
    Rst = 1'b1;
    #1;
    check("t1_rst_outs", {ipu_A, ipu_B, ipu_opSel, ipu_Load, out_valid, done, pix_count, busy}, 0);
    @(negedge Clk);
    check("t1_rst_in_ready", 32'(in_ready), 0);
    check("t1_rst_out_data", 32'(out_data), 0);
    Rst = 1'b0;
    @(negedge Clk);
    check("t1_post_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
